// File: rtl/fft_bin_receiver_if.sv
// AXI-Stream style handshake carrying FFT output words into fft_bin_receiver.
// tdata[15:0] is the signed real part, tdata[31:16] the signed imaginary part.
interface fft_bin_receiver_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fft_bin_receiver.sv
// Collects one FFT frame of |re|+|im| magnitudes into a natural-order buffer,
// tracks the peak bin, and holds the frame until the consumer acknowledges it.
module fft_bin_receiver #(
  parameter int FRAME_LEN = 64,
  parameter int ADDR_W    = 6,
  parameter int BITREV    = 1
) (
  input  logic              clk,
  input  logic              reset,
  fft_bin_receiver_if.slave s_axis,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [16:0]       rd_data,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              frame_error,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [16:0]       peak_mag
);

  typedef enum logic [0:0] {
    RECV = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  // Two's-complement magnitude widened to 17 bits so |-32768| stays exact.
  function automatic logic [16:0] abs17(input logic [15:0] v);
    logic [16:0] ext;
    ext = {v[15], v};
    if (v[15]) begin
      abs17 = 17'd0 - ext;
    end else begin
      abs17 = ext;
    end
  endfunction

  function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < ADDR_W; i++) begin
      bit_reverse[i] = a[ADDR_W-1-i];
    end
  endfunction

  state_t            state_r, state_next_s;
  logic              tready_r;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] run_bin_r;
  logic [16:0]       run_mag_r;
  logic              frame_ready_r;
  logic              frame_error_r;
  logic [ADDR_W-1:0] peak_bin_r;
  logic [16:0]       peak_mag_r;
  logic [16:0]       rd_data_r;
  logic [16:0]       mem_r [FRAME_LEN];

  logic              hs_s;
  logic [16:0]       mag_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic              is_end_s;
  logic              good_end_s;
  logic              bad_end_s;
  logic [ADDR_W-1:0] cand_bin_s;
  logic [16:0]       cand_mag_s;

  // Handshake decode, magnitude, write address and running-peak candidate.
  always_comb begin
    hs_s       = s_axis.tvalid & tready_r;
    mag_s      = abs17(s_axis.tdata[15:0]) + abs17(s_axis.tdata[31:16]);
    is_end_s   = (idx_r == LAST_IDX);
    good_end_s = hs_s & s_axis.tlast & is_end_s;
    bad_end_s  = hs_s & (s_axis.tlast ^ is_end_s);
    if (BITREV != 0) begin
      wr_addr_s = bit_reverse(idx_r);
    end else begin
      wr_addr_s = idx_r;
    end
    // Strictly greater: on a tie the earlier arrival keeps the peak.
    if (mag_s > run_mag_r) begin
      cand_bin_s = wr_addr_s;
      cand_mag_s = mag_s;
    end else begin
      cand_bin_s = run_bin_r;
      cand_mag_s = run_mag_r;
    end
  end

  // FSM next state; an ack only counts once the frame is already held.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RECV: begin
        if (good_end_s) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = RECV;
        end
      end
      HOLD: begin
        if (frame_ack) begin
          state_next_s = RECV;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: state_next_s = RECV;
    endcase
  end

  // State register plus the handshake/status flags derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= RECV;
      tready_r      <= 1'b0;
      frame_ready_r <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      tready_r      <= (state_next_s == RECV);
      frame_ready_r <= (state_next_s == HOLD);
      frame_error_r <= bad_end_s;
    end
  end

  // Arrival index, running peak and published peak.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r      <= '0;
      run_bin_r  <= '0;
      run_mag_r  <= 17'd0;
      peak_bin_r <= '0;
      peak_mag_r <= 17'd0;
    end else begin
      if (hs_s) begin
        if (s_axis.tlast || is_end_s) begin
          idx_r     <= '0;
          run_bin_r <= '0;
          run_mag_r <= 17'd0;
        end else begin
          idx_r     <= idx_r + ADDR_W'(1);
          run_bin_r <= cand_bin_s;
          run_mag_r <= cand_mag_s;
        end
      end
      if (good_end_s) begin
        peak_bin_r <= cand_bin_s;
        peak_mag_r <= cand_mag_s;
      end
    end
  end

  // Buffer write port.
  always_ff @(posedge clk) begin
    if (hs_s) begin
      mem_r[wr_addr_s] <= mag_s;
    end
  end

  // Registered buffer read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_r <= 17'd0;
    end else begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign s_axis.tready = tready_r;
  assign frame_ready   = frame_ready_r;
  assign frame_error   = frame_error_r;
  assign peak_bin      = peak_bin_r;
  assign peak_mag      = peak_mag_r;
  assign rd_data       = rd_data_r;

endmodule

// File: tb/tb_fft_bin_receiver.sv
// Directed bench: two receivers (bit-reversed and natural input order) fed the
// same stream, checked against hand-derived magnitudes, peaks and status flags.
module tb_fft_bin_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  rd_addr;
  logic        frame_ack;
  logic [16:0] rd_data0, rd_data1, peak_mag0, peak_mag1;
  logic [5:0]  peak_bin0, peak_bin1;
  logic        fr0, fr1, fe0, fe1;

  fft_bin_receiver_if bus0 ();
  fft_bin_receiver_if bus1 ();

  fft_bin_receiver #(.FRAME_LEN(64), .ADDR_W(6), .BITREV(1)) dut0 (
    .clk(clk), .reset(reset), .s_axis(bus0.slave), .rd_addr(rd_addr),
    .rd_data(rd_data0), .frame_ready(fr0), .frame_ack(frame_ack),
    .frame_error(fe0), .peak_bin(peak_bin0), .peak_mag(peak_mag0));

  fft_bin_receiver #(.FRAME_LEN(64), .ADDR_W(6), .BITREV(0)) dut1 (
    .clk(clk), .reset(reset), .s_axis(bus1.slave), .rd_addr(rd_addr),
    .rd_data(rd_data1), .frame_ready(fr1), .frame_ack(frame_ack),
    .frame_error(fe1), .peak_bin(peak_bin1), .peak_mag(peak_mag1));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [16:0] mag;
  } vec_t;

  vec_t tbl [8];
  int checks = 0;
  int errors = 0;
  int err_pulses0 = 0;
  int err_pulses1 = 0;

  always @(negedge clk) begin
    if (fe0) err_pulses0++;
    if (fe1) err_pulses1++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] brev(input logic [5:0] a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[5-i] = a[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_bus(input logic [15:0] re, input logic [15:0] im, input logic v, input logic last);
    bus0.tdata = {im, re}; bus1.tdata = {im, re};
    bus0.tvalid = v;       bus1.tvalid = v;
    bus0.tlast = last;     bus1.tlast = last;
  endtask

  // Present one word; returns just before the rising edge that accepts it.
  task automatic send_word(input logic [15:0] re, input logic [15:0] im, input logic last);
    int n;
    @(negedge clk);
    set_bus(re, im, 1'b1, last);
    n = 0;
    while (!bus0.tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL tready_timeout: got 0 expected 1");
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    set_bus(16'd0, 16'd0, 1'b0, 1'b0);
    frame_ack = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Word k carries re=scale*k, im=-k, so its magnitude is (scale+1)*k.
  task automatic send_ramp(input int nwords, input int last_at, input int scale);
    for (int k = 0; k < nwords; k++) send_word(16'(scale * k), 16'(-k), k == last_at);
  endtask

  task automatic rd(input logic [5:0] a);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
  endtask

  task automatic check_bufs(input string tag, input int scale);
    logic [5:0] addrs [6];
    addrs = '{6'd0, 6'd1, 6'd5, 6'd17, 6'd32, 6'd63};
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i]);
      chk({tag, "_rd_bitrev"}, 32'(rd_data0), 32'((scale + 1) * brev(addrs[i])));
      chk({tag, "_rd_natural"}, 32'(rd_data1), 32'((scale + 1) * addrs[i]));
    end
  endtask

  task automatic check_peaks(input string tag, input int b0, input int m0, input int b1, input int m1);
    chk({tag, "_peak_bin0"}, 32'(peak_bin0), 32'(b0));
    chk({tag, "_peak_mag0"}, 32'(peak_mag0), 32'(m0));
    chk({tag, "_peak_bin1"}, 32'(peak_bin1), 32'(b1));
    chk({tag, "_peak_mag1"}, 32'(peak_mag1), 32'(m1));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tready"}, 32'(bus0.tready), 32'd0);
    chk({tag, "_frame_ready"}, 32'(fr0 | fr1), 32'd0);
    chk({tag, "_frame_error"}, 32'(fe0 | fe1), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data0 | rd_data1), 32'd0);
    check_peaks(tag, 0, 0, 0, 0);
  endtask

  task automatic do_ack();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    chk("ack_tready", 32'(bus0.tready), 32'd1);
    chk("ack_frame_ready", 32'(fr0), 32'd0);
  endtask

  initial begin
    int hold_accepts;
    tbl[0] = '{16'd0,      16'd0,      17'd0};
    tbl[1] = '{16'd1,      16'hFFFF,   17'd2};
    tbl[2] = '{16'd32767,  16'd32767,  17'd65534};
    tbl[3] = '{16'hFFFF,   16'd0,      17'd1};
    tbl[4] = '{16'h8000,   16'd32767,  17'd65535};
    tbl[5] = '{16'h8000,   16'h8000,   17'd65536};
    tbl[6] = '{16'd100,    16'hFF38,   17'd300};
    tbl[7] = '{16'hFFFB,   16'd5,      17'd10};

    reset = 1'b1;
    rd_addr = 6'd0;
    frame_ack = 1'b0;
    set_bus(16'd0, 16'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("tready_after_reset", 32'(bus0.tready), 32'd1);

    // Good frame: arrival k magnitude 2k.
    send_ramp(64, 63, 1);
    idle(2);
    chk("good_frame_ready", 32'(fr0 & fr1), 32'd1);
    chk("good_tready_hold", 32'(bus0.tready), 32'd0);
    chk("good_no_error", 32'(err_pulses0 + err_pulses1), 32'd0);
    check_peaks("good", 63, 126, 63, 126);
    check_bufs("good", 1);

    // Backpressure: offers in HOLD must not be taken.
    hold_accepts = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_bus(16'd1000, 16'd1000, 1'b1, 1'b1);
      if (bus0.tready) hold_accepts++;
    end
    chk("hold_accepts", 32'(hold_accepts), 32'd0);
    @(negedge clk);
    set_bus(16'd0, 16'd0, 1'b0, 1'b0);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    chk("bp_ack_tready", 32'(bus0.tready), 32'd1);
    chk("bp_ack_frame_ready", 32'(fr0), 32'd0);
    check_bufs("bp_unchanged", 1);
    check_peaks("bp", 63, 126, 63, 126);

    // Early tlast on the 10th word.
    send_ramp(10, 9, 7);
    idle(2);
    chk("early_err0", 32'(err_pulses0), 32'd1);
    chk("early_err1", 32'(err_pulses1), 32'd1);
    chk("early_frame_ready", 32'(fr0), 32'd0);
    chk("early_tready", 32'(bus0.tready), 32'd1);
    check_peaks("early", 63, 126, 63, 126);

    // Next good frame, with an ack raised on the very cycle frame_ready rises.
    for (int k = 0; k < 64; k++) send_word(16'(2 * k), 16'(-k), k == 63);
    frame_ack = 1'b1;
    idle(2);
    chk("ack_same_cycle_ignored", 32'(fr0), 32'd1);
    chk("after_early_err", 32'(err_pulses0), 32'd1);
    check_peaks("after_early", 63, 189, 63, 189);
    check_bufs("after_early", 2);
    do_ack();

    // Missing tlast, then a good frame.
    send_ramp(64, -1, 4);
    idle(2);
    chk("missing_err0", 32'(err_pulses0), 32'd2);
    chk("missing_frame_ready", 32'(fr0), 32'd0);
    check_peaks("missing", 63, 189, 63, 189);
    send_ramp(64, 63, 0);
    idle(2);
    chk("after_missing_ready", 32'(fr0 & fr1), 32'd1);
    chk("after_missing_err", 32'(err_pulses1), 32'd2);
    check_peaks("after_missing", 63, 63, 63, 63);
    check_bufs("after_missing", 0);
    do_ack();

    // Extremes table; arrival 9 repeats the arrival-5 maximum to exercise ties.
    for (int k = 0; k < 64; k++) begin
      if (k < 8) send_word(tbl[k].re, tbl[k].im, 1'b0);
      else if (k == 9) send_word(tbl[5].re, tbl[5].im, 1'b0);
      else send_word(16'd0, 16'd0, k == 63);
    end
    idle(2);
    chk("ext_frame_ready", 32'(fr0), 32'd1);
    for (int k = 0; k < 8; k++) begin
      rd(brev(6'(k)));
      chk("ext_rd_bitrev", 32'(rd_data0), 32'(tbl[k].mag));
      rd(6'(k));
      chk("ext_rd_natural", 32'(rd_data1), 32'(tbl[k].mag));
    end
    rd(6'd9);
    chk("ext_rd_bin9", 32'(rd_data1), 32'd65536);
    check_peaks("ext_tie", 40, 65536, 5, 65536);
    do_ack();

    // Asynchronous reset in the middle of a frame.
    send_ramp(30, -1, 5);
    #2 reset = 1'b1;
    #1 check_zero("mid_reset");
    @(negedge clk);
    set_bus(16'd0, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_zero("held_reset");
    reset = 1'b0;
    @(negedge clk);
    send_ramp(64, 63, 1);
    idle(2);
    chk("post_reset_ready", 32'(fr0 & fr1), 32'd1);
    chk("post_reset_no_err", 32'(err_pulses0 + err_pulses1), 32'd4);
    check_peaks("post_reset", 63, 126, 63, 126);
    check_bufs("post_reset", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bin_receiver.md
FFT_BIN_RECEIVER -- requirements
Module: fft_bin_receiver

Interface
REQ-001 Parameter FRAME_LEN, default 64: bins per FFT frame; power of two, 8 to 1024.
REQ-002 Parameter ADDR_W, default 6: log2(FRAME_LEN).
REQ-003 Parameter BITREV, default 1: 1 means the FFT core emits bins in bit-reversed order; 0 means natural order.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port s_axis_tdata, input, 32: FFT output word; [15:0] signed real, [31:16] signed imaginary.
REQ-007 Port s_axis_tvalid, input, 1: upstream word valid.
REQ-008 Port s_axis_tlast, input, 1: last bin of frame.
REQ-009 Port s_axis_tready, output, 1: receiver accepts a word.
REQ-010 Port rd_addr, input, ADDR_W: natural-order bin index to read.
REQ-011 Port rd_data, output, 17: unsigned magnitude of bin rd_addr.
REQ-012 Port frame_ready, output, 1: complete frame held in buffer.
REQ-013 Port frame_ack, input, 1: consumer releases buffer.
REQ-014 Port frame_error, output, 1: one-cycle pulse on a tlast framing fault.
REQ-015 Port peak_bin, output, ADDR_W: natural index of the largest bin in the last good frame.
REQ-016 Port peak_mag, output, 17: magnitude at peak_bin.

Function
REQ-017 The block SHALL implement two states: RECV (s_axis_tready=1) and HOLD (s_axis_tready=0).
REQ-018 A handshake SHALL occur only on a cycle with tvalid=1 and tready=1; tdata is ignored on all other cycles.
REQ-019 Magnitude SHALL be |re|+|im| in 17-bit unsigned; |-32768| = 32768, so the maximum is 65536 with no saturation.
REQ-020 On each handshake, the magnitude SHALL be written to buf[bitrev(idx)] when BITREV=1, else to buf[idx]; idx then increments.
REQ-021 A handshake with idx=FRAME_LEN-1 and tlast=1 SHALL:
- reset idx to 0;
- copy the running peak to peak_bin/peak_mag;
- set frame_ready=1;
- enter HOLD on the next cycle.
REQ-022 A handshake with tlast=1 and idx<FRAME_LEN-1 SHALL pulse frame_error, reset idx to 0, clear the running peak, and remain in RECV; the frame is discarded.
REQ-023 A handshake with idx=FRAME_LEN-1 and tlast=0 SHALL pulse frame_error, wrap idx to 0, clear the running peak, and remain in RECV.
REQ-024 Running peak tracking:
- update when the magnitude is strictly greater than the running peak, so ties keep the lower arrival index;
- store the natural-order index;
- clear to 0/0 at the start of each frame.
REQ-025 In HOLD, frame_ack=1 SHALL clear frame_ready and return to RECV on the next cycle; frame_ack in RECV is ignored.
REQ-026 A frame_ack sampled on the same cycle that frame_ready rises SHALL be ignored; the ack must arrive while frame_ready=1.
REQ-027 rd_data SHALL be registered with 1-cycle latency from rd_addr, in any state.
REQ-028 rd_data SHALL be guaranteed only in HOLD.
REQ-029 peak_bin/peak_mag SHALL hold their values until the next good frame completes; errored frames do not alter them.
REQ-030 Buffer storage SHALL be an inferred simple dual-port RAM, FRAME_LEN x 17.

Reset
REQ-031 While reset=1, the block SHALL hold: state=RECV, idx=0, running peak=0, frame_ready=0, frame_error=0, peak_bin=0, peak_mag=0, rd_data=0.
REQ-032 s_axis_tready SHALL be 1 from the first clock edge after reset deasserts.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; buffer contents need not be cleared.

Verification
REQ-034 Good frame:
- Stimulus: 64 words, BITREV=1, arrival k carries re=k, im=-k; tlast on the 64th word.
- Response: frame_ready=1; tready=0; reading natural address a returns 2*bitrev(a); peak_bin=bitrev(63)=63, peak_mag=126.
REQ-035 Early tlast:
- Stimulus: tlast on the 10th word.
- Response: one frame_error pulse; frame_ready stays 0; the next 64-word frame completes normally.
REQ-036 Missing tlast:
- Stimulus: 64 words with no tlast, then a good frame.
- Response: frame_error pulses at word 64; the second frame produces frame_ready with correct data.
REQ-037 Backpressure/ack:
- Stimulus: in HOLD, tvalid=1 for 20 cycles, then frame_ack for 1 cycle.
- Response: no words accepted during HOLD; tready=1 on the cycle after the ack; the buffer is unchanged until new handshakes.
REQ-038 Extremes and ties:
- Stimulus: bin 5 carries re=-32768, im=-32768; bin 9 carries the same.
- Response: magnitude 65536; peak_bin=5 (tie rule).
REQ-039 Async reset:
- Stimulus: reset pulse at word 30 of a frame, then a full frame.
- Response: all outputs are 0 during reset; the following frame completes correctly with no frame_error.
